// File: rtl/calc_seq_ctrl_if.sv
// ALU handshake bundle between the calculator sequencer (master) and the ALU (slave).
interface calc_seq_ctrl_if;
    logic        alu_start;
    logic [2:0]  alu_func;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_done;
    logic [31:0] alu_result;

    modport master (
        output alu_start, alu_func, alu_a, alu_b,
        input  alu_done, alu_result
    );

    modport slave (
        input  alu_start, alu_func, alu_a, alu_b,
        output alu_done, alu_result
    );
endinterface

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: debounced button press launches one ALU operation,
// waits for completion or timeout, and holds the result for the display.
module calc_seq_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk_g,
    input  logic                  rst,
    input  logic                  button,
    input  logic [2:0]            func,
    input  logic [7:0]            num1,
    input  logic [7:0]            num2,
    calc_seq_ctrl_if.master       alu,
    output logic [31:0]           cal_result,
    output logic                  result_valid,
    output logic                  err,
    output logic                  busy
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic            deb_level_q, deb_level_d;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
    logic            press_q, press_d;
    logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [2:0]      alu_func_q, alu_func_d;
    logic [7:0]      alu_a_q, alu_a_d;
    logic [7:0]      alu_b_q, alu_b_d;
    logic [31:0]     cal_result_q, cal_result_d;
    logic            err_q, err_d;
    logic            result_valid_q, result_valid_d;
    logic            req_valid;

    always_ff @(posedge clk_g) begin
        if (rst) begin
            state_q        <= S_IDLE;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            deb_level_q    <= 1'b0;
            deb_cnt_q      <= '0;
            press_q        <= 1'b0;
            wait_cnt_q     <= '0;
            alu_func_q     <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            cal_result_q   <= '0;
            err_q          <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= button;
            sync2_q        <= sync1_q;
            deb_level_q    <= deb_level_d;
            deb_cnt_q      <= deb_cnt_d;
            press_q        <= press_d;
            wait_cnt_q     <= wait_cnt_d;
            alu_func_q     <= alu_func_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            cal_result_q   <= cal_result_d;
            err_q          <= err_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Any cycle where the synchronized input agrees with the level restarts the count.
    always_comb begin
        deb_level_d = deb_level_q;
        deb_cnt_d   = '0;
        if (sync2_q != deb_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_level_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
        press_d = deb_level_d & ~deb_level_q;
    end

    assign req_valid = (func <= 3'b101) && !((func == 3'b011) && (num2 == 8'd0));

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        alu_func_d     = alu_func_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        cal_result_d   = cal_result_q;
        err_d          = err_q;
        result_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (press_q) begin
                    if (req_valid) begin
                        alu_func_d = func;
                        alu_a_d    = num1;
                        alu_b_d    = num2;
                        state_d    = S_START;
                    end else begin
                        cal_result_d   = '0;
                        err_d          = 1'b1;
                        result_valid_d = 1'b1;
                    end
                end
            end
            S_START: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // Completion wins over a timeout landing in the same cycle.
                if (alu.alu_done) begin
                    cal_result_d   = alu.alu_result;
                    err_d          = 1'b0;
                    result_valid_d = 1'b1;
                    state_d        = S_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_d          = 1'b1;
                    result_valid_d = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        alu.alu_start = (state_q == S_START);
        busy          = (state_q != S_IDLE);
    end

    assign alu.alu_func  = alu_func_q;
    assign alu.alu_a     = alu_a_q;
    assign alu.alu_b     = alu_b_q;
    assign cal_result    = cal_result_q;
    assign err           = err_q;
    assign result_valid  = result_valid_q;

endmodule

// File: doc/calc_seq_ctrl.md
CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 500000: number of consecutive stable cycles required to accept a new button level.
REQ-002 Parameter TIMEOUT, default 64: maximum number of WAIT cycles allowed for alu_done.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; ports clk_g and rst.
REQ-004 Ports SHALL be:
- clk_g  in  1  system clock
- rst  in  1  synchronous reset, active-high
- button  in  1  raw push-button, undebounced
- func  in  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110/111 invalid
- num1  in  8  operand A
- num2  in  8  operand B
- alu_start  out  1  one-cycle start strobe to the ALU
- alu_func  out  3  latched opcode
- alu_a  out  8  latched operand A
- alu_b  out  8  latched operand B
- alu_done  in  1  ALU completion strobe
- alu_result  in  32  ALU result, valid while alu_done=1
- cal_result  out  32  held result for the display
- result_valid  out  1  one-cycle pulse when cal_result/err are updated
- err  out  1  error flag for the last operation
- busy  out  1  high whenever state is not IDLE

Function
REQ-005 Button input SHALL pass through a 2-flop synchronizer before the debouncer.
REQ-006 Debounced level SHALL change only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any intermediate bounce restarts the count from 0.
REQ-007 A press event SHALL be a single-cycle pulse on each 0->1 transition of the debounced level; a held button yields exactly one event.
REQ-008 FSM states SHALL be IDLE, START and WAIT.
REQ-009 IDLE, press event in cycle t with a valid request: latch func/num1/num2 into alu_func/alu_a/alu_b at end of t; state START in t+1.
REQ-010 START: alu_start=1 for exactly one cycle; then WAIT, with wait counter cleared.
REQ-011 WAIT: alu_done is sampled starting at the first WAIT cycle; alu_done asserted during START or IDLE SHALL be ignored.
REQ-012 alu_done=1 in WAIT cycle d: at d+1 cal_result<=alu_result, err<=0, result_valid=1 for one cycle, state IDLE.
REQ-013 Timeout: the wait counter increments each WAIT cycle without alu_done; when TIMEOUT cycles elapse, the next cycle sets err<=1, keeps cal_result unchanged, pulses result_valid, and returns to IDLE.
REQ-014 A press with func=110/111, or with func=011 and num2=0, SHALL NOT start the ALU; the next cycle sets cal_result<=0, err<=1 and pulses result_valid, and the state stays IDLE.
REQ-015 Press events while busy=1 SHALL be discarded, not queued; changes to func/num1/num2 while busy SHALL NOT affect alu_func/alu_a/alu_b.
REQ-016 alu_func/alu_a/alu_b SHALL hold their values until the next accepted press.
REQ-017 busy SHALL be 1 in START and WAIT, and 0 in IDLE.
REQ-018 Minimum press-to-result_valid latency SHALL be 3 cycles (press t, START t+1, WAIT t+2 with done, result t+3).

Reset
REQ-019 rst=1 at a clock edge SHALL force:
- state IDLE
- all outputs 0 (including cal_result, err, result_valid, busy, alu_start)
- debounce counter 0, debounced level 0, synchronizer flops 0
REQ-020 Reset in START or WAIT SHALL abandon the operation; a later alu_done SHALL be ignored while in IDLE.
REQ-021 A button held high through reset release SHALL produce one press event after sync + DEB_CYCLES cycles.

Verification (DEB_CYCLES=4, TIMEOUT=8)
REQ-022 func=000, num1=0x12, num2=0x34, clean press, ALU model returns 0x46 one cycle after start -> one alu_start pulse, alu_a=0x12, alu_b=0x34, cal_result=0x00000046, err=0, single result_valid pulse.
REQ-023 Button bouncing 1-0-1-0 with runs of 2 cycles, then held 10 cycles -> exactly one alu_start.
REQ-024 func=011, num2=0x00, press -> no alu_start, cal_result=0, err=1, result_valid one pulse, busy stays 0.
REQ-025 ALU model never asserts alu_done -> after 8 WAIT cycles: err=1, previous cal_result retained, busy=0.
REQ-026 Second press during WAIT with new num1=0xFF -> ignored; alu_a keeps the first value and only one result_valid occurs.
REQ-027 rst asserted in WAIT, alu_done pulsed 2 cycles later -> all outputs 0, no result_valid.
